spi_slave_rx: RTL and testbench



---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync.sv | 29 ++
 rtl/spi_slave_rx.sv | 136 +++++++++++++
 tb/tb_spi_slave_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width, bit-counter width and receiver state encoding.
package spi_pkg;

    localparam int SPI_WORD_W = 16;
    localparam int CNT_W      = $clog2(SPI_WORD_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line, with a configurable reset value.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receiver: oversamples cs_l/sclk/data, rebuilds MSB-first words and offers them on a
// valid/ready port with one-cycle overrun and frame-error pulses.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WORD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         spi_cs_l,
    input  logic                         spi_sclk,
    input  logic                         spi_data,
    output logic [WIDTH-1:0]             rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic                         overrun,
    output logic                         frame_err,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: a word transfers on any clk edge where rx_valid & rx_ready; rx_data is
    // held stable while rx_valid=1 and rx_ready=0, and rx_ready has no effect while rx_valid=0.

    logic cs_s, sclk_s, data_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(spi_cs_l), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(spi_sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
        .clk(clk), .reset(reset), .d(spi_data), .q(data_s)
    );

    rx_state_t        state_q, state_d;
    logic             sclk_d_q, sclk_d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic             rise;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    assign rise    = sclk_s & ~sclk_d_q;
    assign accept  = rx_valid_q & rx_ready;
    assign shifted = {shreg_q[WIDTH-2:0], data_s};

    always_comb begin
        state_d     = state_q;
        sclk_d_d    = sclk_s;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;

        if (accept) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // A rising sclk coincident with cs_l falling is not part of the word.
                if (!cs_s) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (cnt_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                end else if (rise) begin
                    shreg_d = shifted;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d = '0;
                        if (!rx_valid_q || accept) begin
                            rx_data_d  = shifted;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sclk_d_q    <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_d_q    <= sclk_d_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: table of back-to-back words plus hand-written corner sequences.
module tb_spi_slave_rx;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_cs_l;
    logic          spi_sclk;
    logic          spi_data;
    logic          rx_ready;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          overrun;
    logic          frame_err;
    logic [CW-1:0] bit_count;

    spi_slave_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_cs_l  (spi_cs_l),
        .spi_sclk  (spi_sclk),
        .spi_data  (spi_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .frame_err (frame_err),
        .bit_count (bit_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int errors      = 0;
    int checks      = 0;
    int cyc         = 0;
    int last_hi_cyc = 0;
    int beat_cyc    = 0;
    int beats       = 0;
    int ovr_cnt     = 0;
    int fe_cnt      = 0;

    logic [W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every accepted beat must match the head of exp_q
    always @(negedge clk) begin
        if (!reset) begin
            if (overrun)   ovr_cnt++;
            if (frame_err) fe_cnt++;
            if (rx_valid && rx_ready) begin
                logic [W-1:0] exp_w;
                beats++;
                beat_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got %h, expected no word", rx_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (rx_data !== exp_w) begin
                        errors++;
                        $display("FAIL beat_data: got %h, expected %h", rx_data, exp_w);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transmitter protocol: per bit, sclk low one clk then high one clk, MSB first.
    task automatic send_bits(input logic [W-1:0] w, input int n);
        spi_cs_l = 1'b0;
        for (int i = 0; i < n; i++) begin
            spi_data = w[W-1-i];
            spi_sclk = 1'b0;
            tick();
            spi_sclk    = 1'b1;
            last_hi_cyc = cyc;
            tick();
        end
        spi_sclk = 1'b0;
    endtask

    task automatic end_frame();
        spi_cs_l = 1'b1;
        spi_sclk = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_bits(w, W);
        end_frame();
    endtask

    task automatic wait_beats(input string name, input int target);
        for (int k = 0; k < 60 && beats < target; k++) tick();
        check(name, beats, target);
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int b0, o0, f0, bad;

        vecs[0] = '{word: 16'h1234, exp_data: 16'h1234};
        vecs[1] = '{word: 16'hFFFF, exp_data: 16'hFFFF};
        vecs[2] = '{word: 16'h0000, exp_data: 16'h0000};
        vecs[3] = '{word: 16'h8000, exp_data: 16'h8000};
        vecs[4] = '{word: 16'h0001, exp_data: 16'h0001};
        vecs[5] = '{word: 16'h6DB6, exp_data: 16'h6DB6};

        reset    = 1'b1;
        spi_cs_l = 1'b1;
        spi_sclk = 1'b0;
        spi_data = 1'b0;
        rx_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_rx_data",   rx_data,   16'h0000);
        check("rst_rx_valid",  rx_valid,  1'b0);
        check("rst_overrun",   overrun,   1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_bit_count", bit_count, 0);
        tick();
        reset = 1'b0;
        tick();

        // single word, latency from the edge that first samples the final sclk high
        b0 = beats; o0 = ovr_cnt; f0 = fe_cnt;
        exp_q.push_back(16'hA5C3);
        send_word(16'hA5C3);
        wait_beats("a5c3_beat", b0 + 1);
        check("a5c3_latency", beat_cyc - last_hi_cyc, 3);
        repeat (3) tick();
        check("a5c3_no_overrun", ovr_cnt - o0, 0);
        check("a5c3_no_frame",   fe_cnt - f0, 0);
        check("a5c3_valid_low",  rx_valid, 1'b0);

        // table: back-to-back words, 1-clk cs_l-high gap
        b0 = beats; o0 = ovr_cnt; f0 = fe_cnt;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp_data);
            send_word(vecs[i].word);
        end
        wait_beats("table_beats", b0 + 6);
        check("table_no_overrun", ovr_cnt - o0, 0);
        check("table_no_frame",   fe_cnt - f0, 0);

        // overrun: consumer stalled across two words
        rx_ready = 1'b0;
        b0 = beats; o0 = ovr_cnt;
        send_word(16'h00FF);
        send_word(16'hBEEF);
        repeat (6) tick();
        check("ovr_valid_held", rx_valid, 1'b1);
        check("ovr_data_held",  rx_data,  16'h00FF);
        check("ovr_pulse",      ovr_cnt - o0, 1);
        check("ovr_no_beat",    beats - b0, 0);
        exp_q.push_back(16'h00FF);
        rx_ready = 1'b1;
        tick();
        @(negedge clk);
        check("ovr_accept_one", beats - b0, 1);
        check("ovr_valid_fall", rx_valid, 1'b0);
        tick();

        // frame error: 7 bits then cs_l deasserted
        b0 = beats; f0 = fe_cnt;
        send_bits(16'hC000, 7);
        repeat (3) tick();
        check("frame_bit_count_7", bit_count, 7);
        end_frame();
        repeat (4) tick();
        check("frame_pulse",    fe_cnt - f0, 1);
        check("frame_no_beat",  beats - b0, 0);
        check("frame_cnt_zero", bit_count, 0);
        exp_q.push_back(16'h5555);
        send_word(16'h5555);
        wait_beats("after_frame_beat", b0 + 1);

        // sclk toggling with cs_l high must be ignored
        b0 = beats; o0 = ovr_cnt; f0 = fe_cnt; bad = 0;
        spi_cs_l = 1'b1;
        for (int i = 0; i < 20; i++) begin
            spi_data = 1'($urandom_range(0, 1));
            spi_sclk = 1'b1;
            tick();
            if (bit_count != 0) bad++;
            spi_sclk = 1'b0;
            tick();
            if (bit_count != 0) bad++;
        end
        repeat (4) tick();
        check("idle_cnt_nonzero_cycles", bad, 0);
        check("idle_no_beat",   beats - b0, 0);
        check("idle_no_errors", (ovr_cnt - o0) + (fe_cnt - f0), 0);
        check("idle_valid_low", rx_valid, 1'b0);

        // reset mid-word: held rx_data (0x5555) and partial word are discarded
        send_bits(16'hFFFF, 9);
        repeat (3) tick();
        check("pre_reset_bit_count", bit_count, 9);
        reset    = 1'b1;
        spi_cs_l = 1'b1;
        tick();
        check("mid_rst_rx_data",   rx_data,   16'h0000);
        check("mid_rst_rx_valid",  rx_valid,  1'b0);
        check("mid_rst_bit_count", bit_count, 0);
        check("mid_rst_overrun",   overrun,   1'b0);
        check("mid_rst_frame_err", frame_err, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        b0 = beats;
        exp_q.push_back(16'h8001);
        send_word(16'h8001);
        wait_beats("post_reset_beat", b0 + 1);

        repeat (5) tick();
        check("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
